// File: rtl/tulip_dsp_pkg.sv
// Shared constants and types for the tulip DSP pipeline.
package tulip_dsp_pkg;

  localparam int C_ADC_DWIDTH = 24;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } switch_state_t;

endpackage

// File: rtl/tulip_path_switch_if.sv
// Stream bundle around the path switch: upstream, per-chain and downstream valid/ready.
interface tulip_path_switch_if
  import tulip_dsp_pkg::*;
#(
  parameter int G_DWIDTH    = C_ADC_DWIDTH,
  parameter int G_NUM_PATHS = 2
);
  logic [G_DWIDTH-1:0]             din;
  logic                            din_valid;
  logic                            din_ready;
  logic [G_DWIDTH-1:0]             chain_din;
  logic [G_NUM_PATHS-1:0]          chain_din_valid;
  logic [G_NUM_PATHS-1:0]          chain_din_ready;
  logic [G_NUM_PATHS*G_DWIDTH-1:0] chain_dout;
  logic [G_NUM_PATHS-1:0]          chain_dout_valid;
  logic [G_NUM_PATHS-1:0]          chain_dout_ready;
  logic [G_DWIDTH-1:0]             dout;
  logic                            dout_valid;
  logic                            dout_ready;

  modport master (
    output din, din_valid, chain_din_ready, chain_dout, chain_dout_valid, dout_ready,
    input  din_ready, chain_din, chain_din_valid, chain_dout_ready, dout, dout_valid
  );

  modport slave (
    input  din, din_valid, chain_din_ready, chain_dout, chain_dout_valid, dout_ready,
    output din_ready, chain_din, chain_din_valid, chain_dout_ready, dout, dout_valid
  );
endinterface

// File: rtl/tulip_inflight_counter.sv
// Saturating up/down count of samples outstanding inside the active chain.
module tulip_inflight_counter #(
  parameter int G_MAX = 64,
  localparam int CNTW = $clog2(G_MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);
  localparam logic [CNTW-1:0] C_MAX  = CNTW'(G_MAX);
  localparam logic [CNTW-1:0] C_ZERO = CNTW'(0);
  localparam logic [CNTW-1:0] C_ONE  = CNTW'(1);

  logic [CNTW-1:0] r_count;

  // count register; simultaneous inc and dec cancel
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= C_ZERO;
    end else if (inc && !dec && (r_count != C_MAX)) begin
      r_count <= r_count + C_ONE;
    end else if (dec && !inc && (r_count != C_ZERO)) begin
      r_count <= r_count - C_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign full  = (r_count == C_MAX);
  assign empty = (r_count == C_ZERO);
endmodule

// File: rtl/tulip_path_switch.sv
// Glitch-free selector among G_NUM_PATHS processing chains: stalls input and drains
// the active chain before moving to a new path, with an optional drain timeout.
module tulip_path_switch
  import tulip_dsp_pkg::*;
#(
  parameter int G_DWIDTH        = C_ADC_DWIDTH,
  parameter int G_NUM_PATHS     = 2,
  parameter int G_MAX_INFLIGHT  = 64,
  parameter int G_DRAIN_TIMEOUT = 4096,
  parameter int G_RESET_PATH    = 0,
  localparam int SELW = $clog2(G_NUM_PATHS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [SELW-1:0] path_sel,
  output logic [SELW-1:0] active_path,
  output logic            switch_busy,
  output logic            drain_timeout,
  tulip_path_switch_if.slave bus
);
  localparam int TMRW = (G_DRAIN_TIMEOUT > 1) ? $clog2(G_DRAIN_TIMEOUT) : 1;
  localparam bit                C_TMR_EN     = (G_DRAIN_TIMEOUT != 0);
  localparam logic [TMRW-1:0]   C_TMR_LAST   = TMRW'(G_DRAIN_TIMEOUT - 1);
  localparam logic [TMRW-1:0]   C_TMR_ZERO   = TMRW'(0);
  localparam logic [TMRW-1:0]   C_TMR_ONE    = TMRW'(1);
  localparam logic [SELW-1:0]   C_RESET_PATH = SELW'(G_RESET_PATH);
  localparam logic [SELW:0]     C_NUM_PATHS  = (SELW + 1)'(G_NUM_PATHS);

  switch_state_t   r_state, w_state_nxt;
  logic [SELW-1:0] r_active, w_active_nxt;
  logic [SELW-1:0] r_pending, w_pending_nxt;
  logic [TMRW-1:0] r_timer, w_timer_nxt;
  logic            r_busy;
  logic            r_timeout;
  logic            w_timeout_set;
  logic            w_sel_change;
  logic            w_go;
  logic            w_full;
  logic            w_empty;
  logic [G_DWIDTH-1:0] w_chain_dout [G_NUM_PATHS];

  // out-of-range requests never count as a change
  assign w_sel_change = ({1'b0, path_sel} < C_NUM_PATHS) && (path_sel != r_active);
  assign w_go = (r_state == ST_RUN) && enable && !reset && !w_full && !w_sel_change;

  for (genvar g = 0; g < G_NUM_PATHS; g++) begin : g_split
    assign w_chain_dout[g] = bus.chain_dout[g*G_DWIDTH +: G_DWIDTH];
  end

  tulip_inflight_counter #(
    .G_MAX (G_MAX_INFLIGHT)
  ) u_inflight (
    .clk   (clk),
    .reset (reset || !enable),
    .clear (w_timeout_set),
    .inc   (bus.din_valid && bus.din_ready),
    .dec   (bus.dout_valid && bus.dout_ready),
    .full  (w_full),
    .empty (w_empty)
  );

  // zero-latency routing; only the active path sees valid/ready
  always_comb begin
    bus.chain_din        = bus.din;
    bus.chain_din_valid  = {G_NUM_PATHS{1'b0}};
    bus.chain_dout_ready = {G_NUM_PATHS{1'b0}};
    bus.chain_din_valid[r_active]  = bus.din_valid && w_go;
    bus.chain_dout_ready[r_active] = bus.dout_ready;
    bus.din_ready  = bus.chain_din_ready[r_active] && w_go;
    bus.dout       = w_chain_dout[r_active];
    bus.dout_valid = bus.chain_dout_valid[r_active];
  end

  // next-state logic for RUN/DRAIN/SWITCH
  always_comb begin
    w_state_nxt   = r_state;
    w_active_nxt  = r_active;
    w_pending_nxt = r_pending;
    w_timer_nxt   = r_timer;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_sel_change) begin
          w_pending_nxt = path_sel;
          w_timer_nxt   = C_TMR_ZERO;
          w_state_nxt   = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        w_timer_nxt = r_timer + C_TMR_ONE;
        if (w_empty) begin
          w_state_nxt = ST_SWITCH;
        end else if (C_TMR_EN && (r_timer == C_TMR_LAST)) begin
          w_state_nxt   = ST_SWITCH;
          w_timeout_set = 1'b1;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_SWITCH: begin
        w_active_nxt = r_pending;
        w_timer_nxt  = C_TMR_ZERO;
        w_state_nxt  = ST_RUN;
      end
      default: begin
        w_timer_nxt = C_TMR_ZERO;
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // state and status registers; enable low acts exactly like reset
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_state   <= ST_RUN;
      r_active  <= C_RESET_PATH;
      r_pending <= C_RESET_PATH;
      r_timer   <= C_TMR_ZERO;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_active  <= w_active_nxt;
      r_pending <= w_pending_nxt;
      r_timer   <= w_timer_nxt;
      r_busy    <= (w_state_nxt != ST_RUN);
      r_timeout <= r_timeout | w_timeout_set;
    end
  end

  assign active_path   = r_active;
  assign switch_busy   = r_busy;
  assign drain_timeout = r_timeout;
endmodule

// File: doc/tulip_path_switch.md
# tulip_path_switch

Parametrised, glitch-free path selector for the tulip DSP pipeline. It replaces a plain combinational bypass mux with selection among `G_NUM_PATHS` processing chains, one of which is typically a plain wire used as bypass. A path change never drops or duplicates a sample: input is stalled and the active chain is drained before the new selection takes effect. A drain timeout guards against a hung chain. The block sits between the ADC-side stream and the DAC-side stream, wrapping every chain in the tulip DSP top level.

## Interface
- `G_DWIDTH`, default 24: sample width (ADC width).
- `G_NUM_PATHS`, default 2: number of selectable chains, range 2..8.
- `G_MAX_INFLIGHT`, default 64: maximum samples outstanding in the active chain.
- `G_DRAIN_TIMEOUT`, default 4096: drain timeout in cycles; 0 disables the timeout.
- `G_RESET_PATH`, default 0: path that is active after reset.
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: when low, the block behaves exactly as in reset.
- `path_sel`, in, SELW = $clog2(G_NUM_PATHS): requested path.
- `active_path`, out, SELW: path currently routed.
- `switch_busy`, out, 1: high in DRAIN and SWITCH.
- `drain_timeout`, out, 1: sticky flag; set on a forced switch, cleared only by reset.
- `din` / `din_valid` / `din_ready`: G_DWIDTH / 1 / 1; upstream stream, valid/ready.
- `chain_din`, out, G_DWIDTH: broadcast of `din` to all chains.
- `chain_din_valid`, out, G_NUM_PATHS: one-hot, active path only.
- `chain_din_ready`, in, G_NUM_PATHS.
- `chain_dout`, in, G_NUM_PATHS*G_DWIDTH: path p occupies bits [p*G_DWIDTH +: G_DWIDTH].
- `chain_dout_valid`, in, G_NUM_PATHS.
- `chain_dout_ready`, out, G_NUM_PATHS: active path only.
- `dout` / `dout_valid` / `dout_ready`: G_DWIDTH / 1 / 1; downstream stream.

## Operation
- States: RUN, DRAIN, SWITCH. Reset state: RUN, `active_path`=G_RESET_PATH, in-flight count 0, timer 0, `drain_timeout`=0.
- Datapath (combinational, zero latency):
  - `chain_din_valid[a]` = `din_valid` && go; `din_ready` = `chain_din_ready[a]` && go.
  - go = (state==RUN) && enable && !reset && (inflight < G_MAX_INFLIGHT) && !(path_sel_valid && path_sel != a).
  - `dout` = `chain_dout[a]`; `dout_valid` = `chain_dout_valid[a]`; `chain_dout_ready[a]` = `dout_ready`.
  - All non-active ready/valid outputs are 0.
- In-flight counter:
  - +1 on an input handshake, -1 on an output handshake, unchanged when both occur in the same cycle.
  - Saturates at 0 and never exceeds G_MAX_INFLIGHT.
- RUN: when `path_sel` < G_NUM_PATHS and differs from `active_path`, latch pending = path_sel and go to DRAIN. Out-of-range `path_sel` is ignored.
- DRAIN:
  - Outputs keep draining; no inputs are accepted; timer increments each cycle.
  - inflight==0 → SWITCH.
  - Timer reaches G_DRAIN_TIMEOUT (non-zero) → SWITCH, set `drain_timeout`, clear inflight.
- SWITCH (one cycle): `active_path` <= pending, timer cleared → RUN.
- Changes on `path_sel` during DRAIN/SWITCH are ignored. They are re-evaluated in RUN, so a request back to the original path causes a second switch.
- Reset or enable low mid-DRAIN: return to reset state immediately; pending is discarded.

## Timing
- Data latency through the block: 0 cycles.
- Idle switch (inflight 0): request seen in cycle N (`din_ready` low in N). DRAIN is N+1, SWITCH is N+2, RUN with the new `active_path` from N+3. Minimum stall is 3 cycles.
- Busy switch: SWITCH follows the first DRAIN cycle in which inflight==0 at the start of the cycle.
- `switch_busy` and `active_path` are registered.

## Structure
- `tulip_dsp_pkg` holds C_ADC_DWIDTH and the state enum (RUN/DRAIN/SWITCH).
- One sub-module, `tulip_inflight_counter`: up/down counter with full/empty flags, parameter G_MAX.

## Test plan
- Idle switch: G_NUM_PATHS=2, path 0 and path 1 both wires, path_sel 0→1 with no traffic. Expect `din_ready` low for exactly 3 cycles, then `active_path`=1 and `switch_busy` low.
- Busy switch: path 0 is an 8-cycle delay line, continuous ramp 0..999 input, path_sel→1 at sample 500. Expect output 0..999 in order with no gaps in value and none duplicated; `active_path` changes only after sample 499 exits.
- Backpressure: `dout_ready` low for 100 cycles with G_MAX_INFLIGHT=4 on a deep chain. Expect exactly 4 inputs accepted, then `din_ready` stays 0 until output resumes.
- Timeout: path 0 chain holds `chain_dout_valid` low with inflight=3 and G_DRAIN_TIMEOUT=16, then request path 1. Expect SWITCH 16 cycles into DRAIN, `drain_timeout`=1 sticky, inflight=0.
- Invalid and late requests: path_sel=3 with G_NUM_PATHS=3 is ignored. Toggle path_sel 0→1→0 during DRAIN: expect a switch to 1, then a second switch back to 0.
- Reset mid-DRAIN: assert reset for 1 cycle. Expect state RUN, `active_path`=G_RESET_PATH, `switch_busy`=0, `drain_timeout`=0.
